keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_pkg.sv | 36 +++
 rtl/keypad_tick_gen.sv | 32 +++
 rtl/keypad_scanner.sv | 210 +++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Shared types and constants for the 4x4 keypad scanner:
//               FSM state encoding, key-code width and the row/column to
//               key-code mapping.
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  localparam int c_KEY_W      = 4;
  // key code = row * c_ROW_STRIDE + col
  localparam int c_ROW_STRIDE = 4;

  // Lowest-index row that is pulled low (rows are active-low).
  function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
    if (!rows[0])      return 2'd0;
    else if (!rows[1]) return 2'd1;
    else if (!rows[2]) return 2'd2;
    else               return 2'd3;
  endfunction

  function automatic logic [c_KEY_W-1:0] key_map(input logic [1:0] row,
                                                 input logic [1:0] col);
    return c_KEY_W'(int'(row) * c_ROW_STRIDE + int'(col));
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : keypad_tick_gen
// Description : Free-running divider 0..DIV-1; o_tick is high for the single
//               cycle in which the count equals DIV-1.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_tick_gen #(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic o_tick
);

  localparam int c_CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [c_CNT_W-1:0] r_cnt;
  logic               w_last;

  assign w_last = (r_cnt == c_CNT_W'(DIV - 1));
  assign o_tick = w_last;

  // Count up and restart from zero after the terminal value.
  always_ff @(posedge clk) begin
    if (rst)         r_cnt <= '0;
    else if (w_last) r_cnt <= '0;
    else             r_cnt <= r_cnt + 1'b1;
  end

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scanner
// Description : 4x4 matrix keypad scanner with debounce. Strobes one column at
//               a time, samples rows on each scan tick, debounces press and
//               release and reports the accepted key code.
//               Optional macro KEYPAD_REPEAT_EN adds auto-repeat of key_valid
//               while a key stays pressed.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  import keypad_pkg::*;

  localparam int c_DB_W = $clog2(DEBOUNCE_CNT + 1);

  state_t              r_state, w_state_nxt;
  logic [1:0]          r_col,   w_col_nxt;
  logic [1:0]          r_row,   w_row_nxt;
  logic [c_DB_W-1:0]   r_match, w_match_nxt;
  logic [c_KEY_W-1:0]  r_code,  w_code_nxt;
  logic                r_valid, w_valid_nxt;

  logic                w_tick;
  logic                w_row_low;
  logic [c_DB_W-1:0]   w_match_inc;
  logic                w_match_done;

`ifdef KEYPAD_REPEAT_EN
  localparam int c_REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int c_REP_W   = $clog2(c_REP_MAX + 1);

  logic [c_REP_W-1:0]  r_rep_cnt, w_rep_cnt_nxt;
  logic                r_rep_first, w_rep_first_nxt;
  logic [c_REP_W-1:0]  w_rep_inc;
  logic [c_REP_W-1:0]  w_rep_thr;

  assign w_rep_inc = (r_rep_cnt == '1) ? r_rep_cnt : r_rep_cnt + 1'b1;
  assign w_rep_thr = r_rep_first ? c_REP_W'(REPEAT_DELAY) : c_REP_W'(REPEAT_RATE);
`endif

  keypad_tick_gen #(
    .DIV (SCAN_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .o_tick (w_tick)
  );

  // Only the latched row matters once a key has been captured.
  assign w_row_low    = ~row_in[r_row];
  assign w_match_inc  = (r_match == c_DB_W'(DEBOUNCE_CNT)) ? r_match : r_match + 1'b1;
  assign w_match_done = (w_match_inc == c_DB_W'(DEBOUNCE_CNT));

  assign col_out   = ~(4'b0001 << r_col);
  assign key_code  = r_code;
  assign key_valid = r_valid;
  assign key_held  = (r_state == ST_PRESSED) || (r_state == ST_RELEASE);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_SCAN;
      r_col   <= 2'd0;
      r_row   <= 2'd0;
      r_match <= '0;
      r_code  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_col   <= w_col_nxt;
      r_row   <= w_row_nxt;
      r_match <= w_match_nxt;
      r_code  <= w_code_nxt;
      r_valid <= w_valid_nxt;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  // Auto-repeat interval counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b0;
    end else begin
      r_rep_cnt   <= w_rep_cnt_nxt;
      r_rep_first <= w_rep_first_nxt;
    end
  end
`endif

  // Next-state logic: scan, debounce press, hold, debounce release.
  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_match_nxt = r_match;
    w_code_nxt  = r_code;
    w_valid_nxt = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    w_rep_cnt_nxt   = r_rep_cnt;
    w_rep_first_nxt = r_rep_first;
`endif
    case (r_state)
      ST_SCAN: begin
        if (w_tick) begin
          if (row_in == 4'hF) begin
            w_col_nxt = r_col + 2'd1;
          end else begin
            w_row_nxt   = lowest_low_row(row_in);
            w_match_nxt = c_DB_W'(1);
            if (DEBOUNCE_CNT <= 1) begin
              w_state_nxt = ST_PRESSED;
              w_code_nxt  = key_map(lowest_low_row(row_in), r_col);
              w_valid_nxt = 1'b1;
              w_match_nxt = '0;
`ifdef KEYPAD_REPEAT_EN
              w_rep_cnt_nxt   = '0;
              w_rep_first_nxt = 1'b1;
`endif
            end else begin
              w_state_nxt = ST_DEBOUNCE;
            end
          end
        end
      end
      ST_DEBOUNCE: begin
        if (w_tick) begin
          if (w_row_low) begin
            w_match_nxt = w_match_inc;
            if (w_match_done) begin
              w_state_nxt = ST_PRESSED;
              w_code_nxt  = key_map(r_row, r_col);
              w_valid_nxt = 1'b1;
              w_match_nxt = '0;
`ifdef KEYPAD_REPEAT_EN
              w_rep_cnt_nxt   = '0;
              w_rep_first_nxt = 1'b1;
`endif
            end
          end else begin
            w_state_nxt = ST_SCAN;
            w_col_nxt   = r_col + 2'd1;
            w_match_nxt = '0;
          end
        end
      end
      ST_PRESSED: begin
        if (w_tick && !w_row_low) begin
          if (DEBOUNCE_CNT <= 1) begin
            w_state_nxt = ST_SCAN;
            w_col_nxt   = r_col + 2'd1;
            w_match_nxt = '0;
          end else begin
            w_state_nxt = ST_RELEASE;
            w_match_nxt = c_DB_W'(1);
          end
        end
`ifdef KEYPAD_REPEAT_EN
        else if (w_tick) begin
          if (w_rep_inc >= w_rep_thr) begin
            w_valid_nxt     = 1'b1;
            w_rep_cnt_nxt   = '0;
            w_rep_first_nxt = 1'b0;
          end else begin
            w_rep_cnt_nxt = w_rep_inc;
          end
        end
`endif
      end
      ST_RELEASE: begin
        if (w_tick) begin
          if (!w_row_low) begin
            w_match_nxt = w_match_inc;
            if (w_match_done) begin
              w_state_nxt = ST_SCAN;
              w_col_nxt   = r_col + 2'd1;
              w_match_nxt = '0;
            end
          end else begin
            // Release glitch: key is still down, resume holding silently.
            w_state_nxt = ST_PRESSED;
            w_match_nxt = '0;
          end
        end
      end
      default: begin
        w_state_nxt = ST_SCAN;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_scanner
// Description : Self-checking bench for keypad_scanner (SCAN_DIV=4,
//               DEBOUNCE_CNT=3). A 16-key switch matrix drives row_in from
//               col_out; a tick-level behavioural model predicts the outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DB       = 3;
  localparam int RD       = 5;
  localparam int RR       = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] keys = '0;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_dut_valid = 0;
  int n_exp_valid = 0;

  keypad_scanner #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DB)
`ifdef KEYPAD_REPEAT_EN
    ,
    .REPEAT_DELAY (RD),
    .REPEAT_RATE  (RR)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Switch matrix: a closed key (r,c) pulls row r low while column c is strobed.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  // ---------------- behavioural reference model ----------------
  int         m_tcnt      = 0;
  logic [1:0] m_col       = 2'd0;
  logic [1:0] m_row       = 2'd0;
  bit         m_locked    = 1'b0;  // a key is latched (debouncing or accepted)
  bit         m_acc       = 1'b0;  // the latched key was accepted
  int         m_streak    = 0;     // consecutive low samples before acceptance
  int         m_hi        = 0;     // consecutive high samples after acceptance
  logic [3:0] m_code      = 4'h0;
  bit         m_valid     = 1'b0;
  bit         m_last_tick = 1'b0;
  int         m_rep       = 0;     // low ticks spent held after acceptance
  logic       m_tick;
  logic [3:0] exp_col;

  assign m_tick  = (m_tcnt == SCAN_DIV - 1);
  assign exp_col = ~(4'b0001 << m_col);

  function automatic logic [1:0] first_low(input logic [3:0] rows);
    for (int r = 0; r < 4; r++) if (!rows[r]) return 2'(r);
    return 2'd0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_tcnt <= 0; m_col <= 2'd0; m_row <= 2'd0; m_locked <= 1'b0; m_acc <= 1'b0;
      m_streak <= 0; m_hi <= 0; m_code <= 4'h0; m_valid <= 1'b0; m_last_tick <= 1'b0;
      m_rep <= 0;
    end else begin
      m_last_tick <= m_tick;
      m_valid     <= 1'b0;
      m_tcnt      <= m_tick ? 0 : m_tcnt + 1;
      if (m_tick) begin
        if (!m_locked) begin
          if (row_in != 4'hF) begin
            m_locked <= 1'b1;
            m_row    <= first_low(row_in);
            m_streak <= 1;
          end else begin
            m_col <= m_col + 2'd1;
          end
        end else if (!m_acc) begin
          if (!row_in[m_row]) begin
            m_streak <= m_streak + 1;
            if (m_streak + 1 >= DB) begin
              m_acc   <= 1'b1;
              m_valid <= 1'b1;
              m_code  <= 4'(int'(m_row) * 4 + int'(m_col));
              m_hi    <= 0;
              m_rep   <= 0;
            end
          end else begin
            m_locked <= 1'b0;
            m_col    <= m_col + 2'd1;
          end
        end else begin
          if (row_in[m_row]) begin
            if (m_hi + 1 >= DB) begin
              m_locked <= 1'b0; m_acc <= 1'b0; m_hi <= 0; m_col <= m_col + 2'd1;
            end else begin
              m_hi <= m_hi + 1;
            end
          end else if (m_hi > 0) begin
            m_hi <= 0;
          end
`ifdef KEYPAD_REPEAT_EN
          else begin
            if ((m_rep + 1 == RD) || ((m_rep + 1 > RD) && ((m_rep + 1 - RD) % RR == 0)))
              m_valid <= 1'b1;
            m_rep <= m_rep + 1;
          end
`endif
        end
      end
    end
  end

  // Pulse tallies (count the previous cycle's pulse at each rising edge).
  always @(posedge clk) begin
    if (key_valid === 1'b1) n_dut_valid++;
    if (m_valid)            n_exp_valid++;
  end

  // ---------------- stimulus utilities ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      while (!m_last_tick) @(negedge clk);
    end
  endtask

  // Align to the first cycle a given column is strobed.
  task automatic wait_col(input logic [3:0] target, output bit ok);
    int guard = 0;
    ok = 1'b0;
    while (col_out == target && guard < 64) begin @(negedge clk); guard++; end
    while (col_out != target && guard < 64) begin @(negedge clk); guard++; end
    ok = (col_out == target);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    n_cmp += 4;
    if (col_out !== 4'b1110) begin n_fail++; $display("FAIL reset_col: got %b want 1110", col_out); end
    if (key_code !== 4'h0)   begin n_fail++; $display("FAIL reset_code: got %h want 0", key_code); end
    if (key_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_valid: got %b want 0", key_valid); end
    if (key_held !== 1'b0)   begin n_fail++; $display("FAIL reset_held: got %b want 0", key_held); end
  endtask

  task automatic test_idle_scan();
    logic [3:0] seq [4];
    seq[0] = 4'b1110; seq[1] = 4'b1101; seq[2] = 4'b1011; seq[3] = 4'b0111;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      n_cmp += 2;
      if (col_out !== seq[(k / 4) % 4]) begin
        n_fail++; $display("FAIL idle_col cyc%0d: got %b want %b", k, col_out, seq[(k / 4) % 4]);
      end
      if (key_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid cyc%0d: got %b want 0", k, key_valid); end
    end
  endtask

  task automatic test_press();
    bit ok; int base;
    wait_col(4'b1101, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL press_align: col_out %b never reached 1101", col_out); return; end
    base = n_dut_valid;
    keys[9] = 1'b1;
    step(60);
    n_cmp += 5;
    if (n_dut_valid - base !== 1) begin n_fail++; $display("FAIL press_pulses: got %0d want 1", n_dut_valid - base); end
    if (key_code !== 4'h9)    begin n_fail++; $display("FAIL press_code: got %h want 9", key_code); end
    if (key_held !== 1'b1)    begin n_fail++; $display("FAIL press_held: got %b want 1", key_held); end
    if (col_out !== 4'b1101)  begin n_fail++; $display("FAIL press_col: got %b want 1101", col_out); end
    if (n_dut_valid !== n_exp_valid) begin n_fail++; $display("FAIL press_model: got %0d want %0d", n_dut_valid, n_exp_valid); end
    keys[9] = 1'b0;
    step(30);
    n_cmp++;
    if (key_held !== 1'b0) begin n_fail++; $display("FAIL press_release_held: got %b want 0", key_held); end
  endtask

  task automatic test_bounce();
    bit ok; int base;
    wait_col(4'b1101, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL bounce_align: col_out %b never reached 1101", col_out); return; end
    base = n_dut_valid;
    keys[9] = 1'b1;
    step(4);
    keys[9] = 1'b0;
    step(6);
    n_cmp += 3;
    if (col_out !== 4'b1011) begin n_fail++; $display("FAIL bounce_col: got %b want 1011", col_out); end
    if (key_held !== 1'b0)   begin n_fail++; $display("FAIL bounce_held: got %b want 0", key_held); end
    if (n_dut_valid - base !== 0) begin n_fail++; $display("FAIL bounce_pulses: got %0d want 0", n_dut_valid - base); end
  endtask

  task automatic test_two_rows();
    bit ok; int base;
    wait_col(4'b1011, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL two_align: col_out %b never reached 1011", col_out); return; end
    base = n_dut_valid;
    keys[2] = 1'b1; keys[14] = 1'b1;
    step(60);
    n_cmp += 2;
    if (key_code !== 4'h2) begin n_fail++; $display("FAIL two_code: got %h want 2", key_code); end
    if (n_dut_valid - base !== 1) begin n_fail++; $display("FAIL two_pulses: got %0d want 1", n_dut_valid - base); end
    keys[2] = 1'b0;
    wait_ticks(1);
    n_cmp += 2;
    if (key_held !== 1'b1) begin n_fail++; $display("FAIL two_release_held: got %b want 1", key_held); end
    if (n_dut_valid - base !== 1) begin n_fail++; $display("FAIL two_release_pulses: got %0d want 1", n_dut_valid - base); end
    step(200);
    n_cmp += 3;
    if (key_code !== 4'hE) begin n_fail++; $display("FAIL two_fresh_code: got %h want e", key_code); end
    if (key_code !== m_code) begin n_fail++; $display("FAIL two_fresh_model: got %h want %h", key_code, m_code); end
    if (n_dut_valid - base !== 2) begin n_fail++; $display("FAIL two_fresh_pulses: got %0d want 2", n_dut_valid - base); end
    keys = '0;
    step(40);
  endtask

  task automatic test_release_glitch();
    bit ok; int base;
    wait_col(4'b1101, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL glitch_align: col_out %b never reached 1101", col_out); return; end
    keys[9] = 1'b1;
    step(60);
    wait_ticks(1);
    base = n_dut_valid;
    keys[9] = 1'b0;
    wait_ticks(2);
    n_cmp++;
    if (key_held !== 1'b1) begin n_fail++; $display("FAIL glitch_held_a: got %b want 1", key_held); end
    keys[9] = 1'b1;
    wait_ticks(1);
    n_cmp++;
    if (key_held !== 1'b1) begin n_fail++; $display("FAIL glitch_held_b: got %b want 1", key_held); end
    keys[9] = 1'b0;
    wait_ticks(2);
    n_cmp++;
    if (key_held !== 1'b1) begin n_fail++; $display("FAIL glitch_held_c: got %b want 1", key_held); end
    wait_ticks(1);
    n_cmp += 3;
    if (key_held !== 1'b0)   begin n_fail++; $display("FAIL glitch_held_d: got %b want 0", key_held); end
    if (col_out !== 4'b1011) begin n_fail++; $display("FAIL glitch_col: got %b want 1011", col_out); end
    if (n_dut_valid - base !== 0) begin n_fail++; $display("FAIL glitch_pulses: got %0d want 0", n_dut_valid - base); end
  endtask

  task automatic test_reset_debounce();
    bit ok; int base;
    wait_col(4'b1101, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL rstdb_align: col_out %b never reached 1101", col_out); return; end
    keys[9] = 1'b1;
    wait_ticks(1);
    base = n_dut_valid;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    n_cmp += 4;
    if (col_out !== 4'b1110) begin n_fail++; $display("FAIL rstdb_col: got %b want 1110", col_out); end
    if (key_code !== 4'h0)   begin n_fail++; $display("FAIL rstdb_code: got %h want 0", key_code); end
    if (key_valid !== 1'b0)  begin n_fail++; $display("FAIL rstdb_valid: got %b want 0", key_valid); end
    if (key_held !== 1'b0)   begin n_fail++; $display("FAIL rstdb_held: got %b want 0", key_held); end
    step(100);
    n_cmp += 2;
    if (n_dut_valid - base !== 1) begin n_fail++; $display("FAIL rstdb_pulses: got %0d want 1", n_dut_valid - base); end
    if (key_code !== 4'h9) begin n_fail++; $display("FAIL rstdb_code2: got %h want 9", key_code); end
    keys = '0;
    step(40);
  endtask

`ifdef KEYPAD_REPEAT_EN
  task automatic test_repeat();
    bit ok; int base; int guard;
    wait_col(4'b1101, ok);
    base = n_dut_valid;
    keys[9] = 1'b1;
    guard = 0;
    while (key_valid !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
    n_cmp++;
    if (guard >= 100) begin n_fail++; $display("FAIL repeat_accept: no key_valid within 100 cycles"); end
    wait_ticks(12);
    keys[9] = 1'b0;
    step(40);
    n_cmp++;
    if (n_dut_valid - base !== 5) begin n_fail++; $display("FAIL repeat_pulses: got %0d want 5", n_dut_valid - base); end
  endtask
`endif

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      int hold; int idle;
      keys = 16'(1 << $urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) keys[$urandom_range(0, 15)] = 1'b1;
      hold = $urandom_range(2, 80);
      idle = $urandom_range(4, 60);
      for (int c = 0; c < hold + idle; c++) begin
        if (c == hold) keys = '0;
        @(negedge clk);
        n_cmp += 4;
        if (col_out !== exp_col)  begin n_fail++; $display("FAIL rand_col it%0d c%0d: got %b want %b", it, c, col_out, exp_col); end
        if (key_valid !== m_valid) begin n_fail++; $display("FAIL rand_valid it%0d c%0d: got %b want %b", it, c, key_valid, m_valid); end
        if (key_held !== m_acc)   begin n_fail++; $display("FAIL rand_held it%0d c%0d: got %b want %b", it, c, key_held, m_acc); end
        if (key_code !== m_code)  begin n_fail++; $display("FAIL rand_code it%0d c%0d: got %h want %h", it, c, key_code, m_code); end
      end
    end
    n_cmp++;
    if (n_dut_valid !== n_exp_valid) begin
      n_fail++; $display("FAIL total_pulses: got %0d want %0d", n_dut_valid, n_exp_valid);
    end
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_press();
    test_bounce();
    test_two_rows();
    test_release_glitch();
    test_reset_debounce();
`ifdef KEYPAD_REPEAT_EN
    test_repeat();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d compared so far", n_cmp);
    $fatal(1);
  end

endmodule
`default_nettype wire
